// File: rtl/gameboy_lcd_pkg.sv
// Shared constants and state encoding for the Game Boy LCD capture path.
package gameboy_lcd_pkg;

   localparam int GB_H_PIXELS     = 160;
   localparam int GB_V_LINES      = 144;
   localparam int GB_FRAME_PIXELS = GB_H_PIXELS * GB_V_LINES;

   typedef enum logic [0:0] {
      WAIT_VSYNC = 1'b0,
      ACTIVE     = 1'b1
   } capture_state_t;

endpackage

// File: rtl/gameboy_sync_edge.sv
// Multi-flop synchronizer for one asynchronous LCD control line, with a
// single-cycle event on the selected edge of the synchronized level.
module gameboy_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit DETECT_RISE = 1'b1
)(
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic event_pulse
);

   logic [SYNC_STAGES-1:0] chain;
   logic                   prev;

   // Shift the raw input through the synchronizer and keep the last level for edge detection.
   always_ff @(posedge clock) begin
      if (reset) begin
         chain <= '0;
         prev  <= 1'b0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], async_in};
         prev  <= chain[SYNC_STAGES-1];
      end
   end

   assign event_pulse = DETECT_RISE ? (chain[SYNC_STAGES-1] & ~prev)
                                    : (~chain[SYNC_STAGES-1] & prev);

endmodule

// File: rtl/gameboy_lcd_capture.sv
// Turns the synchronized LCD pixel stream into frame-buffer writes and flips
// the buffer half only after a complete, well-formed frame.
module gameboy_lcd_capture
   import gameboy_lcd_pkg::*;
#(
   parameter int H_PIXELS    = GB_H_PIXELS,
   parameter int V_LINES     = GB_V_LINES,
   parameter int DATA_WIDTH  = 2,
   parameter int ADDR_WIDTH  = 15,
   parameter int SYNC_STAGES = 2
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  lcd_pix_clk,
   input  logic                  lcd_hsync,
   input  logic                  lcd_vsync,
   input  logic [DATA_WIDTH-1:0] lcd_data,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  write_enable,
   output logic                  buffer_select,
   output logic                  frame_done,
   output logic                  frame_dropped
);

   localparam int XW = $clog2(H_PIXELS + 1);
   localparam int YW = $clog2(V_LINES + 1);
   localparam logic [XW-1:0]         X_END     = XW'(H_PIXELS);
   localparam logic [YW-1:0]         Y_END     = YW'(V_LINES);
   localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(H_PIXELS);

   logic pix_event, line_event, frame_event;
   logic [DATA_WIDTH-1:0] data_sync [SYNC_STAGES];

   capture_state_t state, state_next;
   logic [XW-1:0]         x, x_next;
   logic [YW-1:0]         y, y_next, y_sat;
   logic [ADDR_WIDTH-1:0] line_base, base_next, addr, addr_next;
   logic                  bad, bad_next, pix_ok;
   logic [ADDR_WIDTH-1:0] write_addr_next;
   logic [DATA_WIDTH-1:0] data_out_next;
   logic                  write_enable_next, select_next, done_next, dropped_next;

   gameboy_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b0)) u_pix_sync (
      .clock(clock), .reset(reset), .async_in(lcd_pix_clk), .event_pulse(pix_event));
   gameboy_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b1)) u_hsync_sync (
      .clock(clock), .reset(reset), .async_in(lcd_hsync), .event_pulse(line_event));
   gameboy_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .DETECT_RISE(1'b1)) u_vsync_sync (
      .clock(clock), .reset(reset), .async_in(lcd_vsync), .event_pulse(frame_event));

   // Pixel data takes the same number of stages so it lines up with the pix_clk fall.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
      end else begin
         data_sync[0] <= lcd_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
      end
   end

   // Capture state register.
   always_ff @(posedge clock) begin
      if (reset) state <= WAIT_VSYNC;
      else       state <= state_next;
   end

   // Next-state logic: only the first frame event leaves WAIT_VSYNC.
   always_comb begin
      state_next = state;
      case (state)
         WAIT_VSYNC: begin
            if (frame_event) state_next = ACTIVE;
            else             state_next = WAIT_VSYNC;
         end
         ACTIVE:  state_next = ACTIVE;
         default: state_next = WAIT_VSYNC;
      endcase
   end

   // Counter and output update; writes use pre-update counters, frame > line > pixel.
   always_comb begin
      x_next            = x;
      y_next            = y;
      base_next         = line_base;
      addr_next         = addr;
      bad_next          = bad;
      write_enable_next = 1'b0;
      write_addr_next   = write_addr;
      data_out_next     = data_out;
      select_next       = buffer_select;
      done_next         = 1'b0;
      dropped_next      = 1'b0;
      pix_ok            = (x < X_END) && (y < Y_END);
      y_sat             = (y < Y_END) ? y + 1'b1 : Y_END;
      case (state)
         WAIT_VSYNC: begin
            if (frame_event) begin
               x_next    = '0;
               y_next    = '0;
               base_next = '0;
               addr_next = '0;
               bad_next  = 1'b0;
            end else begin
               bad_next  = bad;
            end
         end
         ACTIVE: begin
            if (pix_event) begin
               if (pix_ok) begin
                  write_enable_next = 1'b1;
                  write_addr_next   = addr;
                  data_out_next     = data_sync[SYNC_STAGES-1];
                  x_next            = x + 1'b1;
                  addr_next         = addr + 1'b1;
               end else begin
                  bad_next = 1'b1;
               end
            end else begin
               write_enable_next = 1'b0;
            end
            if (line_event) begin
               if (x != X_END) bad_next = 1'b1;
               else            bad_next = bad_next;
               x_next    = '0;
               y_next    = y_sat;
               base_next = line_base + LINE_STEP;
               addr_next = line_base + LINE_STEP;
            end else begin
               y_next = y_next;
            end
            // A coincident line event already counts toward the completed-line total.
            if (frame_event) begin
               if ((y_next == Y_END) && !bad_next) begin
                  select_next = ~buffer_select;
                  done_next   = 1'b1;
               end else begin
                  dropped_next = 1'b1;
               end
               x_next    = '0;
               y_next    = '0;
               base_next = '0;
               addr_next = '0;
               bad_next  = 1'b0;
            end else begin
               done_next = 1'b0;
            end
         end
         default: begin
            bad_next = 1'b0;
         end
      endcase
   end

   // Counter and registered-output state.
   always_ff @(posedge clock) begin
      if (reset) begin
         x             <= '0;
         y             <= '0;
         line_base     <= '0;
         addr          <= '0;
         bad           <= 1'b0;
         write_enable  <= 1'b0;
         write_addr    <= '0;
         data_out      <= '0;
         buffer_select <= 1'b0;
         frame_done    <= 1'b0;
         frame_dropped <= 1'b0;
      end else begin
         x             <= x_next;
         y             <= y_next;
         line_base     <= base_next;
         addr          <= addr_next;
         bad           <= bad_next;
         write_enable  <= write_enable_next;
         write_addr    <= write_addr_next;
         data_out      <= data_out_next;
         buffer_select <= select_next;
         frame_done    <= done_next;
         frame_dropped <= dropped_next;
      end
   end

endmodule

// File: doc/gameboy_lcd_capture.md
# gameboy_lcd_capture

Captures the Game Boy LCD pixel stream (pixel clock, line latch, frame sync, 2-bit data) in the system clock domain and converts it into write transactions for `gameboy_frame_buffer`. Sits directly upstream of the frame buffer: drives its `data_in`, `write_addr`, `write_enable` and `buffer_select`. Selects the frame-buffer half to write, and flips it only after a complete, well-formed frame, so the display side always reads a whole frame.

## Interface
- `H_PIXELS`, 160: pixels per line.
- `V_LINES`, 144: lines per frame.
- `DATA_WIDTH`, 2: pixel width.
- `ADDR_WIDTH`, 15: frame-buffer address width; must satisfy `2**ADDR_WIDTH >= H_PIXELS*V_LINES`.
- `SYNC_STAGES`, 2: synchronizer depth for LCD inputs, minimum 2.

Ports:
- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `lcd_pix_clk`  in  1  asynchronous LCD pixel clock; data is valid at its falling edge.
- `lcd_hsync`  in  1  asynchronous line latch; rising edge marks end of line.
- `lcd_vsync`  in  1  asynchronous frame sync; rising edge marks start of frame.
- `lcd_data`  in  DATA_WIDTH  asynchronous pixel data.
- `write_addr`  out  ADDR_WIDTH  frame-buffer write address, equal to y*H_PIXELS + x.
- `data_out`  out  DATA_WIDTH  pixel value; connects to the frame buffer's `data_in`.
- `write_enable`  out  1  one-cycle write strobe.
- `buffer_select`  out  1  half currently being written.
- `frame_done`  out  1  one-cycle pulse when a complete frame is committed.
- `frame_dropped`  out  1  one-cycle pulse when a malformed frame is discarded.

## Operation
- `lcd_pix_clk`, `lcd_hsync`, `lcd_vsync` and `lcd_data` each pass through `SYNC_STAGES` flops. Edge detection runs on the synchronized outputs: pixel event on a pix_clk fall, line event on an hsync rise, frame event on a vsync rise.
- States:
  - `WAIT_VSYNC` (reset state): all pixel and line events are ignored.
  - `ACTIVE`: the first frame event moves the block here, clears the counters and pulses nothing.
- Counters: `x` (0..H_PIXELS), `y` (0..V_LINES), `line_base` (y*H_PIXELS, updated by +H_PIXELS adds; no multiplier), `addr`.
- Pixel event in ACTIVE:
  - If x<H_PIXELS and y<V_LINES: write `data_out`=synced `lcd_data` at `write_addr`=addr, then x++ and addr++.
  - Otherwise: no write, and the frame is marked bad.
- Line event in ACTIVE:
  - If x!=H_PIXELS, mark the frame bad.
  - Then x=0, y++ (saturating at V_LINES), line_base+=H_PIXELS, addr=line_base+H_PIXELS.
- Frame event in ACTIVE:
  - Good frame (y==V_LINES and not bad): toggle `buffer_select`, pulse `frame_done`.
  - Otherwise: pulse `frame_dropped`, leave `buffer_select` unchanged.
  - In both cases, clear x, y, line_base, addr and the bad flag.
- Simultaneous events in one cycle: any write uses the pre-update counters. Counter-update priority is frame > line > pixel; the frame evaluation includes a coincident line event's effect on y.

## Timing
- Reset values: all outputs 0, state WAIT_VSYNC, counters 0.
- All outputs are registered.
- Latency: with clean inputs, an input edge first sampled at clock edge k produces its output effect (`write_enable`, pulse or `buffer_select` change) after edge k+SYNC_STAGES.
- `write_enable`, `frame_done` and `frame_dropped` are high for exactly one cycle.
- `write_addr` and `data_out` are valid while `write_enable`=1 and hold otherwise.
- `clock` must be at least 4× the pixel clock. Each LCD input level must stay stable ≥2 system cycles around its edge.
- Reset mid-frame: the block returns to WAIT_VSYNC and `buffer_select`=0; the partial frame is discarded with no pulse.

## Structure
- Shared package `gameboy_lcd_pkg`:
  - Default constants `GB_H_PIXELS`=160, `GB_V_LINES`=144, `GB_FRAME_PIXELS`=23040.
  - Capture state enum {WAIT_VSYNC, ACTIVE}.
- Sub-module `gameboy_sync_edge`: parameterized SYNC_STAGES synchronizer plus rise/fall detector.
  - Three instances: pix_clk, hsync, vsync.
  - `lcd_data` uses the same stage count with no edge detection, keeping it aligned with pix_clk.

## Test plan
- Reset, vsync, 144 lines × 160 pixels with data (x+y)%4, vsync -> 23040 writes at addr 0..23039 with matching data; `frame_done` pulses once; `buffer_select` goes 0→1.
- 20 pixels and 2 hsyncs before the first vsync after reset -> no writes, no pulses; the first write after vsync is at addr 0.
- Line 10 carries 159 pixels, all other lines are full -> line 11 begins at addr 1760; at the closing vsync `frame_dropped`=1 and `buffer_select` is unchanged.
- Line 0 carries 165 pixels -> only 160 writes (addr 0..159); line 1 starts at 160; the frame is dropped.
- vsync after 50 lines, then a full frame -> first pulse is `frame_dropped`, the next pixel writes addr 0, then `frame_done` with `buffer_select` toggled.
- Reset asserted at line 70, then a full frame -> all outputs 0 during reset; no writes until the next vsync; that frame commits with `buffer_select` 0→1.
